// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the fetch stage (read-only requester
// "if") and the MEM stage (read/write requester "dc"). Only one transaction is
// outstanding at a time. dc has fixed priority, but a streak counter forces an
// if grant after DC_MAX_CONSEC back-to-back dc grants while fetch is waiting.
// The winning request is latched and replayed to the memory over a
// req/gnt/rvalid handshake. The response is routed back to the owner.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   Defined     : a watchdog aborts a transaction after TIMEOUT_CYCLES in
//                 REQ+RESP, sets the sticky err_o and hands the owner a gnt
//                 (if still missing) plus an rvalid with zero data.
//   Not defined : no watchdog, err_o is tied low, the FSM waits forever.
//
// Parameters:
//   WD_SIZE        address/data width
//   DC_MAX_CONSEC  max consecutive dc grants while if_req_i is pending (>=1)
//   TIMEOUT_CYCLES watchdog limit when MEM_ARB_TIMEOUT_EN is defined (>=2)
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   if_req_i/if_addr_i             fetch request (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o/if_rdata_o  fetch accept pulse, data pulse, data
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i/dc_keep_i  data request
//   dc_gnt_o/dc_rvalid_o/dc_rdata_o  data accept pulse, load/store ack, data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_keep_o  memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i  memory accept, response, read data
//   busy_o                         FSM not idle
//   err_o                          sticky watchdog error
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WD_SIZE        = 32,
  parameter int DC_MAX_CONSEC  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_req_i,
  input  logic [WD_SIZE-1:0] if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [WD_SIZE-1:0] if_rdata_o,
  input  logic               dc_req_i,
  input  logic               dc_we_i,
  input  logic [WD_SIZE-1:0] dc_addr_i,
  input  logic [WD_SIZE-1:0] dc_wdata_i,
  input  logic [WD_SIZE-1:0] dc_keep_i,
  output logic               dc_gnt_o,
  output logic               dc_rvalid_o,
  output logic [WD_SIZE-1:0] dc_rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [WD_SIZE-1:0] mem_addr_o,
  output logic [WD_SIZE-1:0] mem_wdata_o,
  output logic [WD_SIZE-1:0] mem_keep_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [WD_SIZE-1:0] mem_rdata_i,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DC} owner_e;

  localparam int SW = $clog2(DC_MAX_CONSEC + 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [WD_SIZE-1:0] addr_q, addr_d;
  logic [WD_SIZE-1:0] wdata_q, wdata_d;
  logic [WD_SIZE-1:0] keep_q, keep_d;
  logic               we_q, we_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic               dc_rvalid_q, dc_rvalid_d;
  logic [WD_SIZE-1:0] if_rdata_q, if_rdata_d;
  logic [WD_SIZE-1:0] dc_rdata_q, dc_rdata_d;
  logic               err_q, err_d;
  logic               timeout;
  logic               streak_full;
  logic               dc_wins;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  // Counts cycles spent in REQ+RESP; IDLE always precedes REQ, so holding it
  // at zero in IDLE clears it on entry to REQ.
  always_comb begin
    timer_d = timer_q;
    if (state_q == IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th cycle of the transaction.
  assign timeout = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  assign streak_full = (streak_q == SW'(DC_MAX_CONSEC));
  assign dc_wins     = dc_req_i && !(if_req_i && streak_full);

  // Memory side is driven purely from the latched request so that a stall
  // keeps everything stable regardless of what the requesters do.
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_keep_o  = keep_q;

  // A timeout while still in REQ also stands in for the missing gnt.
  assign if_gnt_o = (state_q == REQ) && (mem_gnt_i || timeout) && (owner_q == OWN_IF);
  assign dc_gnt_o = (state_q == REQ) && (mem_gnt_i || timeout) && (owner_q == OWN_DC);

  assign if_rvalid_o = if_rvalid_q;
  assign dc_rvalid_o = dc_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dc_rdata_o  = dc_rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

  // Next-state logic: arbitration in IDLE, handshake in REQ/RESP, watchdog
  // abort overriding both, and the starvation streak counter.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    keep_d      = keep_q;
    we_d        = we_q;
    streak_d    = streak_q;
    if_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (!if_req_i) begin
          streak_d = '0;
        end
        if (dc_wins) begin
          owner_d = OWN_DC;
          addr_d  = dc_addr_i;
          wdata_d = dc_wdata_i;
          keep_d  = dc_keep_i;
          we_d    = dc_we_i;
          state_d = REQ;
        end else if (if_req_i) begin
          owner_d = OWN_IF;
          addr_d  = if_addr_i;
          wdata_d = '0;
          keep_d  = '1;
          we_d    = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end else if (owner_q == OWN_DC) begin
            dc_rvalid_d = 1'b1;
            dc_rdata_d  = mem_rdata_i;
          end
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A real response in the same cycle as the timeout still wins.
    if (timeout && !((state_q == RESP) && mem_rvalid_i)) begin
      err_d = 1'b1;
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = '0;
      end else if (owner_q == OWN_DC) begin
        dc_rvalid_d = 1'b1;
        dc_rdata_d  = '0;
      end
      owner_d = OWN_NONE;
      state_d = IDLE;
    end

    // Streak follows the actual grant pulses, not the arbitration decision.
    if (dc_gnt_o && if_req_i && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
    if (if_gnt_o) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      keep_q      <= '0;
      we_q        <= 1'b0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      keep_q      <= keep_d;
      we_q        <= we_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural memory answers
// mem_req_o with a programmable gnt delay and a one-cycle rvalid. Expected
// responses go into a scoreboard queue when a request is issued and are
// popped when the arbiter raises if_rvalid_o or dc_rvalid_o.
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_dc;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_wdata_i;
  logic [31:0] dc_keep_i;
  logic        dc_gnt_o;
  logic        dc_rvalid_o;
  logic [31:0] dc_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_keep_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        busy_o;
  logic        err_o;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  // Memory model controls.
  bit          mem_auto = 1'b1;
  int          gnt_wait = 0;
  int          stall_cnt = 0;
  bit          rv_pending = 1'b0;
  bit          rv_block = 1'b0;
  bit          stray_rv = 1'b0;
  logic [31:0] rv_data = 32'h0;

  mem_port_arbiter #(
    .WD_SIZE(32),
    .DC_MAX_CONSEC(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_keep_i(dc_keep_i), .dc_gnt_o(dc_gnt_o),
    .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_keep_o(mem_keep_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: grants after gnt_wait stalled cycles, answers one cycle later.
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (stray_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0BAD0;
      stray_rv     = 1'b0;
    end else if (rv_pending && !rv_block) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rv_data;
      rv_pending   = 1'b0;
    end
    if (mem_auto && mem_req_o) begin
      if (stall_cnt >= gnt_wait) begin
        mem_gnt_i  = 1'b1;
        rv_pending = 1'b1;
        rv_data    = mem_we_o ? 32'h0 : rd_model(mem_addr_o);
        stall_cnt  = 0;
      end else begin
        stall_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we_o); end
    total++; if ({if_gnt_o, dc_gnt_o} !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt got=%b exp=00", {if_gnt_o, dc_gnt_o}); end
    total++; if ({if_rvalid_o, dc_rvalid_o} !== 2'b00) begin bad++; $display("[TB] FAIL reset_rvalid got=%b exp=00", {if_rvalid_o, dc_rvalid_o}); end
    total++; if (if_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_rdata got=%h exp=0", if_rdata_o); end
    total++; if (dc_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_dc_rdata got=%h exp=0", dc_rdata_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", err_o); end
    reset_n = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    bit   got;
    int   lat;
    if_addr_i = 32'h100;
    if_req_i  = 1'b1;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b1});
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_req_early got=%b exp=0", mem_req_o); end
    tick();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL fetch_req_n1 got=%b exp=1", mem_req_o); end
    total++; if (mem_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL fetch_addr got=%h exp=100", mem_addr_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL fetch_we got=%b exp=0", mem_we_o); end
    total++; if (mem_keep_o !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL fetch_keep got=%h exp=ffffffff", mem_keep_o); end
    total++; if ({if_gnt_o, dc_gnt_o} !== 2'b10) begin bad++; $display("[TB] FAIL fetch_gnt got=%b exp=10", {if_gnt_o, dc_gnt_o}); end
    if_req_i = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      if (if_rvalid_o || dc_rvalid_o) got = 1'b1;
    end
    total++;
    if (!got || sb.size() == 0) begin
      bad++; $display("[TB] FAIL fetch_rvalid_wait got=none exp=rvalid");
    end else begin
      e = sb.pop_front();
      if (lat != 2) begin bad++; $display("[TB] FAIL fetch_latency got=%0d exp=2", lat); end
      total++; if ({if_rvalid_o, dc_rvalid_o} !== {!e.is_dc, e.is_dc}) begin bad++; $display("[TB] FAIL fetch_owner got=%b exp=%b", {if_rvalid_o, dc_rvalid_o}, {!e.is_dc, e.is_dc}); end
      total++; if (if_rdata_o !== e.data) begin bad++; $display("[TB] FAIL fetch_data got=%h exp=%h", if_rdata_o, e.data); end
      total++; if (dc_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL fetch_dc_rdata got=%h exp=0", dc_rdata_o); end
    end
  endtask

  task automatic test_store();
    exp_t e;
    bit   got;
    dc_we_i    = 1'b1;
    dc_addr_i  = 32'h204;
    dc_wdata_i = 32'h12;
    dc_keep_i  = 32'h000000FF;
    dc_req_i   = 1'b1;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    tick();
    total++; if (mem_we_o !== 1'b1) begin bad++; $display("[TB] FAIL store_we got=%b exp=1", mem_we_o); end
    total++; if (mem_addr_o !== 32'h204) begin bad++; $display("[TB] FAIL store_addr got=%h exp=204", mem_addr_o); end
    total++; if (mem_wdata_o !== 32'h12) begin bad++; $display("[TB] FAIL store_wdata got=%h exp=12", mem_wdata_o); end
    total++; if (mem_keep_o !== 32'hFF) begin bad++; $display("[TB] FAIL store_keep got=%h exp=ff", mem_keep_o); end
    total++; if ({if_gnt_o, dc_gnt_o} !== 2'b01) begin bad++; $display("[TB] FAIL store_gnt got=%b exp=01", {if_gnt_o, dc_gnt_o}); end
    dc_req_i = 1'b0;
    dc_we_i  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (if_rvalid_o || dc_rvalid_o) got = 1'b1;
    end
    total++;
    if (!got || sb.size() == 0) begin
      bad++; $display("[TB] FAIL store_ack_wait got=none exp=rvalid");
    end else begin
      e = sb.pop_front();
      if ({if_rvalid_o, dc_rvalid_o} !== {!e.is_dc, e.is_dc}) begin bad++; $display("[TB] FAIL store_ack_owner got=%b exp=%b", {if_rvalid_o, dc_rvalid_o}, {!e.is_dc, e.is_dc}); end
    end
  endtask

  task automatic test_contention();
    bit   order[$];
    bit   exp_order[6] = '{1, 1, 1, 1, 0, 1};
    exp_t e;
    if_addr_i = 32'h300;
    dc_addr_i = 32'h400;
    dc_we_i   = 1'b0;
    if_req_i  = 1'b1;
    dc_req_i  = 1'b1;
    for (int i = 0; i < 100 && (order.size() < 6 || sb.size() != 0); i++) begin
      tick();
      if (if_gnt_o) begin
        order.push_back(1'b0);
        sb.push_back('{1'b0, rd_model(32'h300), 1'b1});
      end
      if (dc_gnt_o) begin
        order.push_back(1'b1);
        sb.push_back('{1'b1, rd_model(32'h400), 1'b1});
      end
      if (order.size() >= 6) begin
        if_req_i = 1'b0;
        dc_req_i = 1'b0;
      end
      if (if_rvalid_o || dc_rvalid_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("[TB] FAIL cont_unexpected_rvalid got=%b exp=none", {if_rvalid_o, dc_rvalid_o});
        end else begin
          e = sb.pop_front();
          if ({if_rvalid_o, dc_rvalid_o} !== {!e.is_dc, e.is_dc}) begin
            bad++; $display("[TB] FAIL cont_owner got=%b exp=%b", {if_rvalid_o, dc_rvalid_o}, {!e.is_dc, e.is_dc});
          end else if ((e.is_dc ? dc_rdata_o : if_rdata_o) !== e.data) begin
            bad++; $display("[TB] FAIL cont_data got=%h exp=%h", e.is_dc ? dc_rdata_o : if_rdata_o, e.data);
          end
        end
      end
    end
    if_req_i = 1'b0;
    dc_req_i = 1'b0;
    total++; if (order.size() < 6) begin bad++; $display("[TB] FAIL cont_grant_count got=%0d exp=6", order.size()); end
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      total++;
      if (order[k] !== exp_order[k]) begin
        bad++; $display("[TB] FAIL cont_order[%0d] got=%s exp=%s", k, order[k] ? "dc" : "if", exp_order[k] ? "dc" : "if");
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL cont_drain got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_gnt_stall();
    exp_t e;
    bit   got;
    gnt_wait  = 5;
    dc_addr_i = 32'h500;
    dc_we_i   = 1'b0;
    dc_req_i  = 1'b1;
    sb.push_back('{1'b1, rd_model(32'h500), 1'b1});
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_req[%0d] got=%b exp=1", k, mem_req_o); end
      total++; if (mem_addr_o !== 32'h500) begin bad++; $display("[TB] FAIL stall_addr[%0d] got=%h exp=500", k, mem_addr_o); end
      total++; if (dc_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_gnt[%0d] got=%b exp=0", k, dc_gnt_o); end
    end
    tick();
    total++; if (dc_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_gnt6 got=%b exp=1", dc_gnt_o); end
    dc_req_i = 1'b0;
    gnt_wait = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (if_rvalid_o || dc_rvalid_o) got = 1'b1;
    end
    total++;
    if (!got || sb.size() == 0) begin
      bad++; $display("[TB] FAIL stall_rvalid_wait got=none exp=rvalid");
    end else begin
      e = sb.pop_front();
      if (dc_rdata_o !== e.data || dc_rvalid_o !== 1'b1) begin
        bad++; $display("[TB] FAIL stall_data got=%h/%b exp=%h/1", dc_rdata_o, dc_rvalid_o, e.data);
      end
    end
  endtask

  task automatic test_reset_in_resp();
    rv_block  = 1'b1;
    if_addr_i = 32'h600;
    if_req_i  = 1'b1;
    tick();
    if_req_i = 1'b0;
    tick();
    total++; if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL resp_state got=%b%b exp=10", busy_o, mem_req_o); end
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    rv_block   = 1'b0;
    rv_pending = 1'b0;
    stray_rv   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({if_rvalid_o, dc_rvalid_o, busy_o} !== 3'b000) begin
        bad++; $display("[TB] FAIL stray_rvalid[%0d] got=%b exp=000", k, {if_rvalid_o, dc_rvalid_o, busy_o});
      end
    end
    total++; if (if_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL stray_rdata got=%h exp=0", if_rdata_o); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    mem_auto  = 1'b0;
    dc_addr_i = 32'h700;
    dc_we_i   = 1'b0;
    dc_req_i  = 1'b1;
    sb.push_back('{1'b1, 32'h0, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (dc_gnt_o !== (k == 8)) begin bad++; $display("[TB] FAIL tmo_gnt[%0d] got=%b exp=%b", k, dc_gnt_o, k == 8); end
    end
    dc_req_i = 1'b0;
    tick();
    e = sb.pop_front();
    total++; if (dc_rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL tmo_rvalid got=%b exp=1", dc_rvalid_o); end
    total++; if (dc_rdata_o !== e.data) begin bad++; $display("[TB] FAIL tmo_rdata got=%h exp=%h", dc_rdata_o, e.data); end
    total++; if (err_o !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err got=%b exp=1", err_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL tmo_busy got=%b exp=0", busy_o); end
    tick();
    total++; if (err_o !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err_sticky got=%b exp=1", err_o); end
    mem_auto = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL err_tied got=%b exp=0", err_o); end
  endtask
`endif

  initial begin
    if_req_i   = 1'b0;
    if_addr_i  = 32'h0;
    dc_req_i   = 1'b0;
    dc_we_i    = 1'b0;
    dc_addr_i  = 32'h0;
    dc_wdata_i = 32'h0;
    dc_keep_i  = 32'h0;
    reset_n    = 1'b0;
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_gnt_stall();
    test_reset_in_resp();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the fetch stage (read-only requester "if") and the MEM stage (read/write requester "dc").
- Allows one outstanding transaction at a time.
- Fixed priority to dc, with a streak limit so fetch cannot starve.
- Registers the winning request, drives the memory with a req/gnt/rvalid handshake, and returns read data or write acknowledge to the owning requester.

Parameters:
WD_SIZE, 32, address/data width
DC_MAX_CONSEC, 4, max consecutive dc grants while if_req_i is pending (must be >=1)
TIMEOUT_CYCLES, 64, watchdog limit for MEM_ARB_TIMEOUT_EN (must be >=2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
if_req_i  in  1  fetch request; held stable until if_gnt_o
if_addr_i  in  WD_SIZE  fetch address
if_gnt_o  out  1  fetch request accepted by memory (pulse)
if_rvalid_o  out  1  fetch data valid (pulse)
if_rdata_o  out  WD_SIZE  fetch data
dc_req_i  in  1  data request; held stable until dc_gnt_o
dc_we_i  in  1  1 = store
dc_addr_i  in  WD_SIZE  data address, word aligned
dc_wdata_i  in  WD_SIZE  store data
dc_keep_i  in  WD_SIZE  store bit mask
dc_gnt_o  out  1  data request accepted (pulse)
dc_rvalid_o  out  1  load data / store ack valid (pulse)
dc_rdata_o  out  WD_SIZE  load data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  WD_SIZE  memory address
mem_wdata_o  out  WD_SIZE  memory write data
mem_keep_o  out  WD_SIZE  memory write mask
mem_gnt_i  in  1  memory accepts request
mem_rvalid_i  in  1  memory response (loads and stores)
mem_rdata_i  in  WD_SIZE  memory read data
busy_o  out  1  state != IDLE
err_o  out  1  sticky timeout error (see Optional Feature)

Behaviour:
- Reset is synchronous active-low, sampled on posedge clk. It forces:
  - state IDLE
  - all *_gnt_o, *_rvalid_o, mem_req_o, mem_we_o, busy_o, err_o = 0
  - rdata outputs = 0
  - dc streak counter = 0
  - owner = none
- Reset mid-transaction drops the transaction. A later mem_rvalid_i arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitrate on the current cycle's requests.
  - Winner is dc if dc_req_i and NOT (if_req_i and streak == DC_MAX_CONSEC); otherwise if, when if_req_i is set.
  - Latch winner's addr, we, wdata, keep and owner into registers; go to REQ.
  - For an if win, latched we = 0 and keep = all ones.
  - No request: stay in IDLE.
- REQ:
  - mem_req_o = 1; mem_* driven from the latched registers only.
  - When mem_gnt_i = 1, the owner's *_gnt_o = 1 combinationally in the same cycle; go to RESP next cycle.
  - mem_gnt_i = 0: hold all outputs stable.
- RESP:
  - mem_req_o = 0.
  - When mem_rvalid_i = 1, register mem_rdata_i into the owner's rdata and pulse the owner's *_rvalid_o in the next cycle; go to IDLE.
  - Non-owner rvalid/rdata stay 0 / unchanged.
  - Store ack: dc_rvalid_o pulses and dc_rdata_o is updated with mem_rdata_i (don't care).
- Back-to-back: rvalid in cycle N, new arbitration in IDLE at N+1, mem_req_o at N+2. Minimum 3 cycles per transaction with zero-wait memory.
- Latency: request seen in IDLE at cycle N gives mem_req_o at N+1.
- Streak counter:
  - Increments (saturating at DC_MAX_CONSEC) on each dc grant with if_req_i = 1 in the grant cycle.
  - Clears on each if grant and whenever if_req_i = 0 in IDLE.
- Simultaneous if_req_i and dc_req_i with streak < limit: dc wins, if waits.
- Requester dropping req before gnt violates protocol. The latched copy still completes.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ+RESP and clears on entering REQ.
  - On reaching TIMEOUT_CYCLES without completion: err_o sets (sticky until reset); the owner receives *_rvalid_o with rdata 0 (if no gnt was given, *_gnt_o pulses in the same cycle); go to IDLE.
- Not defined: no counter; err_o tied 0; the FSM waits indefinitely.

Test Plan:
- Single fetch: if_req_i = 1, addr 0x100, mem_gnt_i = 1 immediately, mem_rvalid_i 1 cycle later with 0xDEADBEEF -> mem_req_o at N+1, if_gnt_o pulse, if_rvalid_o = 1 with if_rdata_o = 0xDEADBEEF; dc outputs stay 0.
- Store: dc_we_i = 1, addr 0x204, wdata 0x12, keep 0x000000FF -> mem_we_o = 1, mem_addr_o = 0x204, mem_keep_o = 0xFF; dc_rvalid_o pulses on ack.
- Contention: if_req_i and dc_req_i held high, DC_MAX_CONSEC = 4 -> grant order dc,dc,dc,dc,if,dc...
- Gnt stall: mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o stable for all 5 cycles, no gnt pulse; gnt on cycle 6.
- Reset during RESP, then stray mem_rvalid_i -> no *_rvalid_o, state IDLE, busy_o = 0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, mem_gnt_i never asserted -> after 8 cycles err_o = 1, dc_gnt_o and dc_rvalid_o pulse, dc_rdata_o = 0.
